// File: rtl/mdu_iter.sv
// mdu_iter: RV M-extension multiply/divide unit.
// Multiplies go through a registered E->M->W pipeline (result two cycles after Execute).
// Divides and remainders use a radix-2 restoring iterative FSM. It holds Execute
// through DivBusyE for a fixed N+1 cycles, where N = 32 for *W ops and XLEN otherwise.
module mdu_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    input  logic [2:0]      Funct3E,
    input  logic            W64E,
    input  logic            MDUActiveE,
    input  logic            IntDivE,
    input  logic            FlushE,
    input  logic            FlushM,
    input  logic            FlushW,
    input  logic            StallM,
    input  logic            StallW,
    output logic            DivBusyE,
    output logic [XLEN-1:0] MDUResultW
);

    localparam int unsigned CntW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MinX = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } div_state_e;

    // Sign-extend a 32-bit value to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    // Zero-extend a 32-bit value to XLEN.
    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    // *W ops only exist on RV64.
    logic w64;
    assign w64 = (XLEN == 64) && W64E;

    // ------------------------------------------------------------------
    // Multiply datapath (Execute)
    // ------------------------------------------------------------------
    logic              mul_a_signed;
    logic              mul_b_signed;
    logic [2*XLEN-1:0] mul_a_ext;
    logic [2*XLEN-1:0] mul_b_ext;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mul_res;

    // Sign-extend operands to 2*XLEN so that one unsigned multiply gives every variant.
    always_comb begin
        mul_a_signed = (Funct3E[1:0] == 2'b01) || (Funct3E[1:0] == 2'b10);
        mul_b_signed = (Funct3E[1:0] == 2'b01);
        mul_a_ext    = {{XLEN{mul_a_signed & ForwardedSrcAE[XLEN-1]}}, ForwardedSrcAE};
        mul_b_ext    = {{XLEN{mul_b_signed & ForwardedSrcBE[XLEN-1]}}, ForwardedSrcBE};
        product      = mul_a_ext * mul_b_ext;
        if (Funct3E[1:0] == 2'b00) begin
            mul_res = w64 ? sext32(product[31:0]) : product[XLEN-1:0];
        end else begin
            mul_res = product[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // Divide operand preparation (used on the start cycle)
    // ------------------------------------------------------------------
    logic            div_signed;
    logic [XLEN-1:0] a_w;
    logic [XLEN-1:0] b_w;
    logic [XLEN-1:0] a_res;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] min_w;
    logic            b_zero;
    logic            ovf;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] quot_init;
    logic [CntW-1:0] cnt_init;

    // Fold *W narrowing, magnitudes, and the two special cases into start-cycle values.
    always_comb begin
        div_signed = ~Funct3E[0];
        if (w64) begin
            a_w = div_signed ? sext32(ForwardedSrcAE[31:0]) : zext32(ForwardedSrcAE[31:0]);
            b_w = div_signed ? sext32(ForwardedSrcBE[31:0]) : zext32(ForwardedSrcBE[31:0]);
        end else begin
            a_w = ForwardedSrcAE;
            b_w = ForwardedSrcBE;
        end
        // Special-case results return A sign-extended from bit 31 even for unsigned *W ops.
        a_res     = w64 ? sext32(ForwardedSrcAE[31:0]) : ForwardedSrcAE;
        a_neg     = div_signed & a_w[XLEN-1];
        b_neg     = div_signed & b_w[XLEN-1];
        a_mag     = a_neg ? -a_w : a_w;
        b_mag     = b_neg ? -b_w : b_w;
        min_w     = w64 ? sext32(32'h8000_0000) : MinX;
        b_zero    = (b_w == '0);
        ovf       = div_signed && (a_w == min_w) && (b_w == '1);
        if (Funct3E[1]) begin
            spec_res = b_zero ? a_res : '0;
        end else begin
            spec_res = b_zero ? '1 : a_res;
        end
        // A 32-bit dividend sits in the top half so the first 32 shifts consume it.
        quot_init = w64 ? (a_mag << (XLEN - 32)) : a_mag;
        cnt_init  = w64 ? CntW'(32) : CntW'(XLEN);
    end

    // ------------------------------------------------------------------
    // Divide FSM
    // ------------------------------------------------------------------
    div_state_e      state_q, state_d;
    logic            start;
    logic            load;
    logic            step;
    logic [CntW-1:0] cnt_q;

    assign start = MDUActiveE & IntDivE & ~FlushE;

    // Next-state and busy decode; busy drops in DONE so Execute can advance.
    always_comb begin
        state_d  = state_q;
        DivBusyE = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    DivBusyE = 1'b1;
                    load     = 1'b1;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (FlushE) begin
                    state_d = StIdle;
                end else begin
                    DivBusyE = 1'b1;
                    step     = 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (FlushE || !StallM) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Restoring division iteration
    // ------------------------------------------------------------------
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] bmag_q;
    logic            qneg_q;
    logic            rneg_q;
    logic            isrem_q;
    logic            w64_q;
    logic            special_q;
    logic [XLEN-1:0] specres_q;

    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quot_nxt;

    // One quotient bit: shift in the next dividend bit and keep the trial difference if it is non-negative.
    always_comb begin
        rem_shift = {rem_q, quot_q[XLEN-1]};
        diff      = rem_shift - {1'b0, bmag_q};
        q_bit     = ~diff[XLEN];
        rem_nxt   = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_nxt  = {quot_q[XLEN-2:0], q_bit};
    end

    // Divider operand/state registers: latch on start, advance while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            quot_q    <= '0;
            rem_q     <= '0;
            bmag_q    <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            isrem_q   <= 1'b0;
            w64_q     <= 1'b0;
            special_q <= 1'b0;
            specres_q <= '0;
            cnt_q     <= '0;
        end else if (load) begin
            quot_q    <= quot_init;
            rem_q     <= '0;
            bmag_q    <= b_mag;
            qneg_q    <= a_neg ^ b_neg;
            rneg_q    <= a_neg;
            isrem_q   <= Funct3E[1];
            w64_q     <= w64;
            special_q <= b_zero | ovf;
            specres_q <= spec_res;
            cnt_q     <= cnt_init;
        end else if (step) begin
            quot_q    <= quot_nxt;
            rem_q     <= rem_nxt;
            cnt_q     <= cnt_q - CntW'(1);
        end else if (state_d == StIdle) begin
            cnt_q     <= '0;
        end
    end

    logic [XLEN-1:0] q_s;
    logic [XLEN-1:0] r_s;
    logic [XLEN-1:0] div_sel;
    logic [XLEN-1:0] div_res;

    // Sign-correct the magnitudes, pick quotient or remainder, and let special cases override.
    always_comb begin
        q_s     = qneg_q ? -quot_q : quot_q;
        r_s     = rneg_q ? -rem_q : rem_q;
        div_sel = isrem_q ? r_s : q_s;
        if (special_q) begin
            div_res = specres_q;
        end else begin
            div_res = w64_q ? sext32(div_sel[31:0]) : div_sel;
        end
    end

    // ------------------------------------------------------------------
    // E->M and M->W result registers
    // ------------------------------------------------------------------
    logic [XLEN-1:0] res_m_d;
    logic [XLEN-1:0] res_m_q;

    // The M register takes a finished divide, a multiply in Execute, or zero for anything else.
    always_comb begin
        res_m_d = '0;
        if ((state_q == StDone) && !FlushE) begin
            res_m_d = div_res;
        end else if (MDUActiveE && !IntDivE && !FlushE) begin
            res_m_d = mul_res;
        end
    end

    // Memory-stage result register.
    always_ff @(posedge clk) begin
        if (reset || FlushM) begin
            res_m_q <= '0;
        end else if (!StallM) begin
            res_m_q <= res_m_d;
        end
    end

    // Writeback-stage result register.
    always_ff @(posedge clk) begin
        if (reset || FlushW) begin
            MDUResultW <= '0;
        end else if (!StallW) begin
            MDUResultW <= res_m_q;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed checks of mdu_iter on one XLEN=32 and one XLEN=64 instance.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  f3;
    logic        w64;
    logic        act32;
    logic        act64;
    logic        intdiv;
    logic        flush_e;
    logic        flush_m;
    logic        flush_w;
    logic        stall_m;
    logic        stall_w;
    logic        busy32;
    logic        busy64;
    logic [31:0] res32;
    logic [63:0] res64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(32)) u_dut32 (
        .clk            (clk),
        .reset          (reset),
        .ForwardedSrcAE (a[31:0]),
        .ForwardedSrcBE (b[31:0]),
        .Funct3E        (f3),
        .W64E           (w64),
        .MDUActiveE     (act32),
        .IntDivE        (intdiv),
        .FlushE         (flush_e),
        .FlushM         (flush_m),
        .FlushW         (flush_w),
        .StallM         (stall_m),
        .StallW         (stall_w),
        .DivBusyE       (busy32),
        .MDUResultW     (res32)
    );

    mdu_iter #(.XLEN(64)) u_dut64 (
        .clk            (clk),
        .reset          (reset),
        .ForwardedSrcAE (a),
        .ForwardedSrcBE (b),
        .Funct3E        (f3),
        .W64E           (w64),
        .MDUActiveE     (act64),
        .IntDivE        (intdiv),
        .FlushE         (flush_e),
        .FlushM         (flush_m),
        .FlushW         (flush_w),
        .StallM         (stall_m),
        .StallW         (stall_w),
        .DivBusyE       (busy64),
        .MDUResultW     (res64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Multiply: operands in Execute for one cycle, result in W two edges later.
    task automatic do_mul(input bit sel64, input logic [2:0] fn, input logic w,
                          input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] exp, input string tag);
        @(posedge clk);
        #1;
        a = av; b = bv; f3 = fn; w64 = w; intdiv = 1'b0;
        act32 = !sel64; act64 = sel64;
        #1;
        check({tag, "_busy"}, {63'b0, sel64 ? busy64 : busy32}, 64'd0);
        @(posedge clk);
        #1;
        act32 = 1'b0; act64 = 1'b0;
        @(posedge clk);
        #1;
        check(tag, sel64 ? res64 : {32'b0, res32}, exp);
    endtask

    // Divide: count busy cycles, release Execute when busy drops, check W result.
    task automatic do_div(input bit sel64, input logic [2:0] fn, input logic w,
                          input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] exp, input int nb, input string tag);
        int cnt;
        cnt = 0;
        @(posedge clk);
        #1;
        a = av; b = bv; f3 = fn; w64 = w; intdiv = 1'b1;
        act32 = !sel64; act64 = sel64;
        #1;
        for (int i = 0; i < 200; i++) begin
            if (sel64 ? busy64 : busy32) cnt++;
            else break;
            @(posedge clk);
            #2;
        end
        check({tag, "_busycnt"}, 64'(cnt), 64'(nb));
        @(posedge clk);
        #1;
        act32 = 1'b0; act64 = 1'b0;
        #1;
        check({tag, "_busyoff"}, {63'b0, sel64 ? busy64 : busy32}, 64'd0);
        @(posedge clk);
        #1;
        check(tag, sel64 ? res64 : {32'b0, res32}, exp);
    endtask

    initial begin
        reset = 1'b1;
        a = '0; b = '0; f3 = '0; w64 = 1'b0;
        act32 = 1'b0; act64 = 1'b0; intdiv = 1'b0;
        flush_e = 1'b0; flush_m = 1'b0; flush_w = 1'b0;
        stall_m = 1'b0; stall_w = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy32", {63'b0, busy32}, 64'd0);
        check("rst_busy64", {63'b0, busy64}, 64'd0);
        check("rst_res32", {32'b0, res32}, 64'd0);
        check("rst_res64", res64, 64'd0);
        reset = 1'b0;

        // XLEN=32 multiplies
        do_mul(1'b0, 3'b000, 1'b0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, "mul_7_m3");
        do_mul(1'b0, 3'b011, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, "mulhu_max");
        do_mul(1'b0, 3'b010, 1'b0, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF, "mulhsu_m1_2");
        do_mul(1'b0, 3'b001, 1'b0, 64'h4000_0000, 64'hFFFF_FFF8, 64'hFFFF_FFFE, "mulh_neg");

        // XLEN=32 divides
        do_div(1'b0, 3'b100, 1'b0, 64'd20, 64'hFFFF_FFFD, 64'hFFFF_FFFA, 33, "div_20_m3");
        do_div(1'b0, 3'b110, 1'b0, 64'd20, 64'hFFFF_FFFD, 64'd2, 33, "rem_20_m3");
        do_div(1'b0, 3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF, 33, "divu_by0");
        do_div(1'b0, 3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 33, "remu_by0");
        do_div(1'b0, 3'b100, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 33, "div_ovf");
        do_div(1'b0, 3'b110, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 33, "rem_ovf");
        do_div(1'b0, 3'b101, 1'b0, 64'hFFFF_FFFF, 64'd16, 64'h0FFF_FFFF, 33, "divu_big");
        do_div(1'b0, 3'b111, 1'b0, 64'hFFFF_FFFF, 64'd16, 64'd15, 33, "remu_big");
        do_div(1'b0, 3'b110, 1'b0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 33, "rem_m7_2");
        do_div(1'b0, 3'b100, 1'b0, 64'hFFFF_FFF9, 64'd0, 64'hFFFF_FFFF, 33, "div_m7_by0");
        do_div(1'b0, 3'b110, 1'b0, 64'hFFFF_FFF9, 64'd0, 64'hFFFF_FFF9, 33, "rem_m7_by0");

        // Flush 10 cycles into a divide: busy drops at once, nothing forwarded.
        @(posedge clk);
        #1;
        a = 64'd100; b = 64'd7; f3 = 3'b100; w64 = 1'b0; intdiv = 1'b1; act32 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush_e = 1'b1;
        #1;
        check("flush_busy", {63'b0, busy32}, 64'd0);
        @(posedge clk);
        #1;
        flush_e = 1'b0; act32 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("flush_nores", {32'b0, res32}, 64'd0);
        do_div(1'b0, 3'b100, 1'b0, 64'd100, 64'd7, 64'd14, 33, "div_after_flush");

        // Reset in the middle of a divide.
        @(posedge clk);
        #1;
        a = 64'd77; b = 64'd3; f3 = 3'b101; intdiv = 1'b1; act32 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1; act32 = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", {63'b0, busy32}, 64'd0);
        reset = 1'b0;
        do_div(1'b0, 3'b111, 1'b0, 64'd77, 64'd3, 64'd2, 33, "remu_after_rst");

        // XLEN=64
        do_div(1'b1, 3'b100, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 33, "divw_ovf");
        do_div(1'b1, 3'b100, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
               64'hFFFF_FFFF_FFFF_FFF2, 65, "div64_100_m7");
        do_div(1'b1, 3'b101, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd14, 33, "divuw");
        do_div(1'b1, 3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 33, "remw_m7_2");
        do_mul(1'b1, 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mulw");
        do_mul(1'b1, 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, "mulhu64");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
